// File: rtl/present_ct_collector_if.sv
// ---------------------------------------------------------------------------
// present_ct_collector_if
//   Ciphertext delivery channel between the collector and its result sink.
//   ct_data  : 64-bit ciphertext {high, low} at the head of the buffer
//   ct_valid : a word is available
//   ct_ready : sink accepts ct_data when ct_valid & ct_ready
//   master   : producer side (collector)
//   slave    : consumer side (sink)
// ---------------------------------------------------------------------------
interface present_ct_collector_if;
    logic [63:0] ct_data;
    logic        ct_valid;
    logic        ct_ready;

    modport master (
        output ct_data,
        output ct_valid,
        input  ct_ready
    );

    modport slave (
        input  ct_data,
        input  ct_valid,
        output ct_ready
    );
endinterface

// File: rtl/present_ct_collector.sv
// ---------------------------------------------------------------------------
// present_ct_collector
//   Reassembles the PRESENT core's 64-bit ciphertext from two 32-bit halves
//   on dout (high half qualified by done1, low half by done2), buffers whole
//   words in a small FIFO and offers them to a sink over valid/ready.
//
//   Parameters : DEPTH (FIFO entries, power of two, >= 2), CNT_W (word counter)
//   clk        : system clock, rising edge
//   rst        : asynchronous active-low reset
//   dout       : ciphertext half from the core
//   done1/2    : level strobes for the high / low half
//   ct_if      : master side of the ciphertext channel (data/valid/ready)
//   full       : FIFO holds DEPTH words
//   ovf_err    : sticky, a word was dropped because the FIFO was full
//   seq_err    : sticky, a low half arrived with no pending high half
//   word_cnt   : words accepted into the FIFO, wraps
// ---------------------------------------------------------------------------
module present_ct_collector #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [31:0]            dout,
    input  logic                   done1,
    input  logic                   done2,
    present_ct_collector_if.master ct_if,
    output logic                   full,
    output logic                   ovf_err,
    output logic                   seq_err,
    output logic [CNT_W-1:0]       word_cnt
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    localparam logic [0:0] ST_IDLE    = 1'b0;
    localparam logic [0:0] ST_HAVE_HI = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [31:0]      hi_q, hi_d;
    logic             done1_q, done2_q;
    logic             seq_err_q, seq_err_d;
    logic             ovf_err_q, ovf_err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [PW-1:0]    wr_q, wr_d;
    logic [PW-1:0]    rd_q, rd_d;
    logic [63:0]      mem_q [DEPTH];
    logic [63:0]      mem_d [DEPTH];

    logic             rise1, rise2;
    logic             push_req, push_ok, pop;
    logic             empty, full_w;
    logic [63:0]      push_word;

    assign rise1 = done1 & ~done1_q;
    assign rise2 = done2 & ~done2_q;

    assign empty  = (wr_q == rd_q);
    assign full_w = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign pop    = ~empty & ct_if.ct_ready;

    // Assembly FSM. In HAVE_HI a simultaneous rise1/rise2 pushes with the old
    // high half and then latches the new one, so rise1 only decides the next
    // state after the push has been formed.
    always_comb begin
        state_d   = state_q;
        hi_d      = hi_q;
        seq_err_d = seq_err_q;
        push_req  = 1'b0;
        push_word = {hi_q, dout};
        case (state_q)
            ST_IDLE: begin
                if (rise2) begin
                    seq_err_d = 1'b1;
                end
                if (rise1) begin
                    hi_d    = dout;
                    state_d = ST_HAVE_HI;
                end
            end
            default: begin
                if (rise2) begin
                    push_req = 1'b1;
                    state_d  = ST_IDLE;
                end
                if (rise1) begin
                    hi_d    = dout;
                    state_d = ST_HAVE_HI;
                end
            end
        endcase
    end

    // A pop in the same cycle frees a slot, so a full FIFO still accepts.
    always_comb begin
        push_ok   = push_req & (~full_w | pop);
        wr_d      = wr_q;
        rd_d      = rd_q;
        cnt_d     = cnt_q;
        ovf_err_d = ovf_err_q;
        mem_d     = mem_q;
        if (push_ok) begin
            mem_d[wr_q[AW-1:0]] = push_word;
            wr_d  = wr_q + PW'(1);
            cnt_d = cnt_q + CNT_W'(1);
        end else if (push_req) begin
            ovf_err_d = 1'b1;
        end
        if (pop) begin
            rd_d = rd_q + PW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            hi_q      <= '0;
            done1_q   <= 1'b0;
            done2_q   <= 1'b0;
            seq_err_q <= 1'b0;
            ovf_err_q <= 1'b0;
            cnt_q     <= '0;
            wr_q      <= '0;
            rd_q      <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            hi_q      <= hi_d;
            done1_q   <= done1;
            done2_q   <= done2;
            seq_err_q <= seq_err_d;
            ovf_err_q <= ovf_err_d;
            cnt_q     <= cnt_d;
            wr_q      <= wr_d;
            rd_q      <= rd_d;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    assign ct_if.ct_data  = mem_q[rd_q[AW-1:0]];
    assign ct_if.ct_valid = ~empty;
    assign full           = full_w;
    assign ovf_err        = ovf_err_q;
    assign seq_err        = seq_err_q;
    assign word_cnt       = cnt_q;

endmodule

// File: tb/tb_present_ct_collector.sv
// ---------------------------------------------------------------------------
// tb_present_ct_collector
//   Directed bench for present_ct_collector (DEPTH=4, CNT_W=8): assembly,
//   back-to-back delivery, overflow, full-with-pop, sequence error and
//   asynchronous reset in mid-operation.
// ---------------------------------------------------------------------------
module tb_present_ct_collector;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] dout = '0;
    logic        done1 = 1'b0;
    logic        done2 = 1'b0;
    logic        full;
    logic        ovf_err;
    logic        seq_err;
    logic [7:0]  word_cnt;

    int total = 0;
    int bad   = 0;

    present_ct_collector_if ctif ();

    present_ct_collector #(
        .DEPTH (4),
        .CNT_W (8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .dout     (dout),
        .done1    (done1),
        .done2    (done2),
        .ct_if    (ctif),
        .full     (full),
        .ovf_err  (ovf_err),
        .seq_err  (seq_err),
        .word_cnt (word_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One high-half strobe cycle, one low-half strobe cycle, one idle cycle.
    task automatic send_word(input logic [31:0] hi, input logic [31:0] lo);
        dout  = hi;
        done1 = 1'b1;
        tick();
        done1 = 1'b0;
        dout  = lo;
        done2 = 1'b1;
        tick();
        done2 = 1'b0;
        tick();
    endtask

    logic [63:0] w [5];

    initial begin
        ctif.ct_ready = 1'b0;
        w[0] = 64'h0000_0001_1111_0001;
        w[1] = 64'h0000_0002_2222_0002;
        w[2] = 64'h0000_0003_3333_0003;
        w[3] = 64'h0000_0004_4444_0004;
        w[4] = 64'h0000_0005_5555_0005;

        // Reset state
        tick();
        tick();
        check("rst_valid", 64'(ctif.ct_valid), 64'd0);
        check("rst_full",  64'(full),          64'd0);
        check("rst_ovf",   64'(ovf_err),       64'd0);
        check("rst_seq",   64'(seq_err),       64'd0);
        check("rst_cnt",   64'(word_cnt),      64'd0);
        check("rst_data",  ctif.ct_data,       64'd0);
        rst = 1'b1;
        tick();

        // Key 0 / PT 0 with long strobes
        dout  = 32'h5579C138;
        done1 = 1'b1;
        tick(); tick(); tick();
        done1 = 1'b0;
        dout  = 32'h7B228445;
        done2 = 1'b1;
        tick();
        check("k0_valid", 64'(ctif.ct_valid), 64'd1);
        check("k0_data",  ctif.ct_data,       64'h5579C1387B228445);
        check("k0_cnt",   64'(word_cnt),      64'd1);
        tick();
        done2 = 1'b0;
        tick();
        check("k0_cnt_hold", 64'(word_cnt), 64'd1);
        check("k0_seq",      64'(seq_err),  64'd0);
        check("k0_ovf",      64'(ovf_err),  64'd0);

        // Back-to-back delivery with ready held high
        ctif.ct_ready = 1'b1;
        check("b2b_first", ctif.ct_data, 64'h5579C1387B228445);
        dout  = 32'hA112FFC7;
        done1 = 1'b1;
        tick();
        check("b2b_pop1_empty", 64'(ctif.ct_valid), 64'd0);
        done1 = 1'b0;
        dout  = 32'h2F68417B;
        done2 = 1'b1;
        tick();
        check("b2b_valid2", 64'(ctif.ct_valid), 64'd1);
        check("b2b_second", ctif.ct_data,       64'hA112FFC72F68417B);
        done2 = 1'b0;
        tick();
        check("b2b_drop_valid", 64'(ctif.ct_valid), 64'd0);
        check("b2b_cnt",        64'(word_cnt),      64'd2);
        ctif.ct_ready = 1'b0;

        // Overflow: five words into a four-entry FIFO
        for (int i = 0; i < 4; i++) send_word(w[i][63:32], w[i][31:0]);
        check("ovf_full4", 64'(full),     64'd1);
        check("ovf_cnt4",  64'(word_cnt), 64'd6);
        check("ovf_pre",   64'(ovf_err),  64'd0);
        send_word(w[4][63:32], w[4][31:0]);
        check("ovf_set",   64'(ovf_err),  64'd1);
        check("ovf_cnt5",  64'(word_cnt), 64'd6);
        check("ovf_full5", 64'(full),     64'd1);
        ctif.ct_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("ovf_drain_valid", 64'(ctif.ct_valid), 64'd1);
            check("ovf_drain_data",  ctif.ct_data,       w[i]);
            tick();
        end
        check("ovf_drained", 64'(ctif.ct_valid), 64'd0);
        ctif.ct_ready = 1'b0;

        // Clear sticky flags, then full FIFO with simultaneous pop
        rst = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        check("rst2_ovf", 64'(ovf_err),  64'd0);
        check("rst2_cnt", 64'(word_cnt), 64'd0);
        for (int i = 0; i < 4; i++) send_word(w[i][63:32], w[i][31:0]);
        check("fp_full", 64'(full), 64'd1);
        dout  = w[4][63:32];
        done1 = 1'b1;
        tick();
        done1 = 1'b0;
        dout  = w[4][31:0];
        done2 = 1'b1;
        ctif.ct_ready = 1'b1;
        tick();
        ctif.ct_ready = 1'b0;
        done2 = 1'b0;
        check("fp_full_stays", 64'(full),     64'd1);
        check("fp_cnt",        64'(word_cnt), 64'd5);
        check("fp_ovf",        64'(ovf_err),  64'd0);
        check("fp_head",       ctif.ct_data,  w[1]);
        tick();
        ctif.ct_ready = 1'b1;
        for (int i = 1; i < 5; i++) begin
            check("fp_drain_data", ctif.ct_data, w[i]);
            tick();
        end
        check("fp_drained", 64'(ctif.ct_valid), 64'd0);
        ctif.ct_ready = 1'b0;

        // Lone low half from IDLE
        dout  = 32'hDEADBEEF;
        done2 = 1'b1;
        tick();
        done2 = 1'b0;
        tick();
        check("seq_set",   64'(seq_err),       64'd1);
        check("seq_nopush",64'(ctif.ct_valid), 64'd0);
        check("seq_cnt",   64'(word_cnt),      64'd5);
        send_word(32'h01234567, 32'h89ABCDEF);
        check("seq_after_data", ctif.ct_data, 64'h0123456789ABCDEF);
        check("seq_after_cnt",  64'(word_cnt), 64'd6);
        ctif.ct_ready = 1'b1;
        tick();
        ctif.ct_ready = 1'b0;

        // Asynchronous reset between rises with two words buffered
        send_word(w[0][63:32], w[0][31:0]);
        send_word(w[1][63:32], w[1][31:0]);
        check("mid_valid_pre", 64'(ctif.ct_valid), 64'd1);
        dout  = 32'hCAFEF00D;
        done1 = 1'b1;
        tick();
        done1 = 1'b0;
        tick();
        #2;
        rst = 1'b0;
        #1;
        check("mid_valid", 64'(ctif.ct_valid), 64'd0);
        check("mid_full",  64'(full),          64'd0);
        check("mid_seq",   64'(seq_err),       64'd0);
        check("mid_cnt",   64'(word_cnt),      64'd0);
        check("mid_data",  ctif.ct_data,       64'd0);
        tick();
        rst = 1'b1;
        tick();
        dout  = 32'h12345678;
        done2 = 1'b1;
        tick();
        done2 = 1'b0;
        tick();
        check("mid_lone_seq",   64'(seq_err),       64'd1);
        check("mid_lone_valid", 64'(ctif.ct_valid), 64'd0);
        check("mid_lone_cnt",   64'(word_cnt),      64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
